// File: rtl/s3_writeback_pkg.sv
// rtl/s3_writeback_pkg.sv - opcode/funct3 codes, memory map and writeback select helper
//
// Shared constants for the writeback stage of the 3-stage RV32I core:
//   OPC_*        major opcodes (instruction[6:0])
//   FNC_*        load funct3 codes (instruction[14:12])
//   NOP_INSTR    bubble encoding (addi x0, x0, 0)
//   REGION_*     memory-map region selectors (address[31:28])
//   *_ADDR       memory-mapped counter addresses
//   TOHOST_CSR   CSR number of the tohost register
package s3_writeback_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] CYCLE_ADDR   = 32'h8000_0010;
  localparam logic [31:0] INSTR_ADDR   = 32'h8000_0014;
  localparam logic [31:0] CNT_RST_ADDR = 32'h8000_0018;
  localparam logic [11:0] TOHOST_CSR   = 12'h51E;

  localparam logic [3:0] REGION_DMEM_A = 4'b0001;
  localparam logic [3:0] REGION_DMEM_B = 4'b0011;
  localparam logic [3:0] REGION_BIOS   = 4'b0100;
  localparam logic [3:0] REGION_IO     = 4'b1000;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_PC4,
    WB_LOAD,
    WB_NONE
  } wb_sel_e;

  // Which value an instruction writes back, purely from its opcode.
  function automatic wb_sel_e wb_sel_of(input logic [6:0] opcode);
    wb_sel_e sel;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_ARI_RTYPE, OPC_ARI_ITYPE: sel = WB_ALU;
      OPC_JAL, OPC_JALR:                                sel = WB_PC4;
      OPC_LOAD:                                         sel = WB_LOAD;
      default:                                          sel = WB_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/s3_load_extend.sv
// rtl/s3_load_extend.sv - load byte/halfword/word extraction with sign/zero extension
//
// Ports:
//   funct3  in  3   load funct3 of the s3 instruction
//   off     in  2   byte offset within the word (address[1:0])
//   word    in  32  raw read word from the selected source
//   result  out 32  aligned, extended load value
module s3_load_extend
  import s3_writeback_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halfword loads use only off[1]; a misaligned off[0] is silently ignored.
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      FNC_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: result = {24'h0, byte_sel};
      FNC_LH:  result = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: result = {16'h0, half_sel};
      default: result = word;   // LW and undefined encodings return the whole word
    endcase
  end

endmodule

// File: rtl/s3_writeback.sv
// rtl/s3_writeback.sv - memory/writeback stage: pipeline register, load return, counters, tohost
//
// Ports:
//   clk, rst         core clock; asynchronous active-high reset
//   flush_s2         kill the s2 instruction (a bubble is captured instead)
//   instruction_s2   instruction in s2
//   alu_result       s2 ALU output (address / result / CSR write data)
//   pc_s2            PC of the s2 instruction
//   mem_wen_s2       s2 instruction is a store
//   csr_we_s2        s2 instruction is a CSR instruction
//   dmem_dout        data memory read word (one cycle after address)
//   bios_dout        BIOS memory read word (same timing)
//   io_rdata         IO read data for 0x8xxx_xxxx non-counter addresses
//   rf_we/wa/wd      register-file write port; rf_wd also forwards to s2
//   instruction_s3   registered s3 instruction for hazard detection
//   csr_tohost       tohost CSR
//   cycle_count      free-running cycle counter
//   instr_count      retired (non-NOP) instruction counter
module s3_writeback
  import s3_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_s2,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_s2,
  input  logic        mem_wen_s2,
  input  logic        csr_we_s2,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic [31:0] io_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] instruction_s3,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  logic [31:0] alu_s3;
  logic [31:0] pc_s3;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic        cnt_clr;
  logic        tohost_we;
  logic        retire;
  wb_sel_e     wb_sel;

  // Side effects of s2 are qualified by flush so a killed instruction leaves no trace.
  assign cnt_clr   = mem_wen_s2 & ~flush_s2 & (alu_result == CNT_RST_ADDR);
  assign tohost_we = csr_we_s2 & ~flush_s2 & (instruction_s2[31:20] == TOHOST_CSR);
  assign retire    = (instruction_s3 != NOP_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_s3 <= NOP_INSTR;
      alu_s3         <= 32'h0;
      pc_s3          <= 32'h0;
    end else begin
      instruction_s3 <= flush_s2 ? NOP_INSTR : instruction_s2;
      alu_s3         <= alu_result;
      pc_s3          <= pc_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_tohost <= 32'h0;
    end else if (tohost_we) begin
      csr_tohost <= alu_result;
    end
  end

  // Clear takes priority over the increment on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= 32'h0;
      instr_count <= 32'h0;
    end else if (cnt_clr) begin
      cycle_count <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // Load source: counters return their current (pre-edge) value.
  always_comb begin
    load_word = 32'h0;
    case (alu_s3[31:28])
      REGION_DMEM_A, REGION_DMEM_B: load_word = dmem_dout;
      REGION_BIOS:                  load_word = bios_dout;
      REGION_IO: begin
        if (alu_s3 == CYCLE_ADDR) begin
          load_word = cycle_count;
        end else if (alu_s3 == INSTR_ADDR) begin
          load_word = instr_count;
        end else begin
          load_word = io_rdata;
        end
      end
      default: load_word = 32'h0;
    endcase
  end

  s3_load_extend u_load_extend (
    .funct3 (instruction_s3[14:12]),
    .off    (alu_s3[1:0]),
    .word   (load_word),
    .result (load_data)
  );

  assign wb_sel = wb_sel_of(instruction_s3[6:0]);
  assign rf_wa  = instruction_s3[11:7];

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_s3;
    case (wb_sel)
      WB_ALU: begin
        rf_we = 1'b1;
        rf_wd = alu_s3;
      end
      WB_PC4: begin
        rf_we = 1'b1;
        rf_wd = pc_s3 + 32'd4;
      end
      WB_LOAD: begin
        rf_we = 1'b1;
        rf_wd = load_data;
      end
      default: begin
        rf_we = 1'b0;
        rf_wd = alu_s3;
      end
    endcase
    // x0 is hardwired to zero, so never request a write to it.
    if (rf_wa == 5'd0) begin
      rf_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_s3_writeback.sv
// tb/tb_s3_writeback.sv - self-checking bench for s3_writeback with a behavioural reference model
module tb_s3_writeback;
  import s3_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_s2;
  logic [31:0] instruction_s2;
  logic [31:0] alu_result;
  logic [31:0] pc_s2;
  logic        mem_wen_s2;
  logic        csr_we_s2;
  logic [31:0] dmem_dout;
  logic [31:0] bios_dout;
  logic [31:0] io_rdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] instruction_s3;
  logic [31:0] csr_tohost;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_instr, m_alu, m_pc, m_cyc, m_icnt, m_toh;

  s3_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .flush_s2       (flush_s2),
    .instruction_s2 (instruction_s2),
    .alu_result     (alu_result),
    .pc_s2          (pc_s2),
    .mem_wen_s2     (mem_wen_s2),
    .csr_we_s2      (csr_we_s2),
    .dmem_dout      (dmem_dout),
    .bios_dout      (bios_dout),
    .io_rdata       (io_rdata),
    .rf_we          (rf_we),
    .rf_wa          (rf_wa),
    .rf_wd          (rf_wd),
    .instruction_s3 (instruction_s3),
    .csr_tohost     (csr_tohost),
    .cycle_count    (cycle_count),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = NOP_INSTR; m_alu = 0; m_pc = 0; m_cyc = 0; m_icnt = 0; m_toh = 0;
  endtask

  // One clock edge of the architectural behaviour, from the pre-edge model state.
  task automatic model_edge();
    logic clr;
    clr = mem_wen_s2 && !flush_s2 && (alu_result == CNT_RST_ADDR);
    if (clr) begin
      m_cyc = 0;
      m_icnt = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (m_instr != NOP_INSTR) m_icnt = m_icnt + 1;
    end
    if (csr_we_s2 && !flush_s2 && instruction_s2[31:20] == 12'h51E) m_toh = alu_result;
    m_instr = flush_s2 ? NOP_INSTR : instruction_s2;
    m_alu = alu_result;
    m_pc = pc_s2;
  endtask

  // Expected {we, wd} from the model's s3 instruction and the current read data.
  function automatic logic [32:0] exp_wb();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] wd, word, sh;
    op = m_instr[6:0];
    f3 = m_instr[14:12];
    we = 1'b0;
    wd = m_alu;
    if (op == 7'h37 || op == 7'h17 || op == 7'h33 || op == 7'h13) begin
      we = 1'b1; wd = m_alu;
    end else if (op == 7'h6F || op == 7'h67) begin
      we = 1'b1; wd = m_pc + 32'd4;
    end else if (op == 7'h03) begin
      we = 1'b1;
      if (m_alu[31:28] == 4'h1 || m_alu[31:28] == 4'h3) word = dmem_dout;
      else if (m_alu[31:28] == 4'h4) word = bios_dout;
      else if (m_alu[31:28] == 4'h8) begin
        if (m_alu == 32'h8000_0010) word = m_cyc;
        else if (m_alu == 32'h8000_0014) word = m_icnt;
        else word = io_rdata;
      end else word = 32'h0;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        sh = word >> (8 * m_alu[1:0]);
        sh = sh & 32'hFF;
        if (f3 == 3'd0 && sh[7]) sh = sh | 32'hFFFF_FF00;
        wd = sh;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        sh = word >> (16 * m_alu[1]);
        sh = sh & 32'hFFFF;
        if (f3 == 3'd1 && sh[15]) sh = sh | 32'hFFFF_0000;
        wd = sh;
      end else begin
        wd = word;
      end
    end
    if (m_instr[11:7] == 5'd0) we = 1'b0;
    return {we, wd};
  endfunction

  task automatic check_all();
    logic [32:0] e;
    e = exp_wb();
    chk("instruction_s3", instruction_s3, m_instr);
    chk("cycle_count", cycle_count, m_cyc);
    chk("instr_count", instr_count, m_icnt);
    chk("csr_tohost", csr_tohost, m_toh);
    chk("rf_we", {31'b0, rf_we}, {31'b0, e[32]});
    chk("rf_wa", {27'b0, rf_wa}, {27'b0, m_instr[11:7]});
    if (e[32]) chk("rf_wd", rf_wd, e[31:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_s2(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] pc,
                        input logic fl);
    instruction_s2 = ins;
    alu_result     = alu;
    pc_s2          = pc;
    flush_s2       = fl;
    mem_wen_s2     = (ins[6:0] == 7'b0100011);
    csr_we_s2      = (ins[6:0] == 7'b1110011);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 7))
      0: a[31:28] = 4'h1;
      1: a[31:28] = 4'h3;
      2: a[31:28] = 4'h4;
      3: a[31:28] = 4'h8;
      4: a = 32'h8000_0010;
      5: a = 32'h8000_0014;
      6: a = ($urandom_range(0, 3) == 0) ? 32'h8000_0018 : a;
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 10)];
    if (ins[6:0] == 7'h73 && $urandom_range(0, 1) == 1) ins[31:20] = 12'h51E;
    if ($urandom_range(0, 15) == 0) ins = NOP_INSTR;
    return ins;
  endfunction

  initial begin
    rst = 1'b1;
    set_s2(NOP_INSTR, 0, 0, 1'b0);
    dmem_dout = 0; bios_dout = 0; io_rdata = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Load extraction
    dmem_dout = 32'h8765_43F1;
    set_s2(32'h0000_0103, 32'h1000_0003, 32'h0, 1'b0); tick();
    chk("lb", rf_wd, 32'hFFFF_FF87);
    set_s2(32'h0000_4103, 32'h1000_0003, 32'h0, 1'b0); tick();
    chk("lbu", rf_wd, 32'h0000_0087);
    set_s2(32'h0000_1103, 32'h1000_0002, 32'h0, 1'b0); tick();
    chk("lh_off2", rf_wd, 32'hFFFF_8765);
    set_s2(32'h0000_2103, 32'h1000_0003, 32'h0, 1'b0); tick();
    chk("lw", rf_wd, 32'h8765_43F1);

    // JAL x1 and ADDI x0
    set_s2(32'h0000_00EF, 32'h0, 32'h0000_1000, 1'b0); tick();
    chk("jal_we", {31'b0, rf_we}, 32'd1);
    chk("jal_wa", {27'b0, rf_wa}, 32'd1);
    chk("jal_wd", rf_wd, 32'h0000_1004);
    set_s2(32'h0050_0013, 32'd5, 32'h0, 1'b0); tick();
    chk("addi_x0_we", {31'b0, rf_we}, 32'd0);

    // Counter clear with a retiring instruction in s3 on the same edge
    set_s2(32'h0050_0093, 32'd5, 32'h0, 1'b0); tick();
    set_s2(32'h0000_2023, 32'h8000_0018, 32'h0, 1'b0); tick();
    chk("clr_cycle", cycle_count, 32'd0);
    chk("clr_instr", instr_count, 32'd0);
    set_s2(NOP_INSTR, 0, 0, 1'b0);
    repeat (3) tick();
    set_s2(32'h0000_2283, 32'h8000_0010, 32'h0, 1'b0); tick();
    chk("cycle_load", rf_wd, 32'd4);

    // tohost write, then flushed write
    set_s2(32'h51E0_D073, 32'd1, 32'h0, 1'b0); tick();
    chk("tohost_wr", csr_tohost, 32'd1);
    set_s2(32'h51E0_D073, 32'd7, 32'h0, 1'b1); tick();
    chk("tohost_flush", csr_tohost, 32'd1);
    chk("flush_nop", instruction_s3, 32'h0000_0013);

    // Cycle counter wrap with only bubbles in flight
    set_s2(NOP_INSTR, 0, 0, 1'b1); tick();
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 release dut.cycle_count;
    m_cyc = 32'hFFFF_FFFF;
    tick();
    chk("wrap_cycle", cycle_count, 32'd0);
    chk("wrap_instr", instr_count, m_icnt);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      dmem_dout = $urandom; bios_dout = $urandom; io_rdata = $urandom;
      set_s2(rand_instr(), rand_addr(), $urandom, ($urandom_range(0, 7) == 0));
      tick();
    end

    // Asynchronous reset mid-cycle with nonzero state
    #2 rst = 1'b1;
    #1;
    chk("rst_instr", instruction_s3, 32'h0000_0013);
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_icnt", instr_count, 32'd0);
    chk("rst_tohost", csr_tohost, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_s2(32'h0050_0093, 32'd9, 32'h0, 1'b0); tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
